router_xy_xbar: RTL and testbench

ROUTER_XY_XBAR -- requirements
Module: router_xy_xbar

---
 rtl/router_xy_pkg.sv | 35 +++
 rtl/router_xy_out_arb.sv | 75 +++++++
 rtl/stream_fifo.sv | 61 ++++++
 rtl/router_xy_xbar.sv | 124 ++++++++++++
 tb/tb_router_xy_xbar.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_xy_pkg.sv
// Shared definitions for the XY mesh router: channel count, port indices, XY route decode.
// Optional feature macro used by this slice: ROUTER_XY_XBAR_WORMHOLE_EN.
package router_xy_pkg;

   localparam int unsigned CHANNEL_NUM = 5;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_e;

   // X is resolved fully before Y; all compares unsigned.
   function automatic port_e xy_route(input int unsigned dest_x,
                                      input int unsigned dest_y,
                                      input int unsigned src_x,
                                      input int unsigned src_y);
      port_e res;
      if (dest_x > src_x)      res = EAST;
      else if (dest_x < src_x) res = WEST;
      else if (dest_y > src_y) res = NORTH;
      else if (dest_y < src_y) res = SOUTH;
      else                     res = LOCAL;
      return res;
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] idx);
      logic [2:0] res;
      res = (idx == 3'(CHANNEL_NUM - 1)) ? 3'd0 : idx + 3'd1;
      return res;
   endfunction

endpackage

// File: rtl/router_xy_out_arb.sv
// Per-output round-robin arbiter with packet lock; pointer moves past the winner on a tail handshake.
// Lock only engages when tail_i is low, i.e. in ROUTER_XY_XBAR_WORMHOLE_EN builds.
module router_xy_out_arb
   import router_xy_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   arstn_i,
   input  logic [CHANNEL_NUM-1:0] req_i,
   input  logic [CHANNEL_NUM-1:0] tail_i,
   input  logic                   ready_i,
   output logic [CHANNEL_NUM-1:0] gnt_o,
   output logic                   valid_o
);

   logic [2:0] ptr_q, ptr_d;
   logic [2:0] owner_q, owner_d;
   logic       lock_q, lock_d;
   logic [2:0] winner;
   logic [2:0] idx;
   logic       found;
   logic       hs;

   always_comb begin
      gnt_o  = '0;
      winner = ptr_q;
      found  = 1'b0;
      idx    = '0;
      if (lock_q) begin
         if (req_i[owner_q]) begin
            gnt_o[owner_q] = 1'b1;
            winner         = owner_q;
         end
      end else begin
         for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
            idx = 3'((32'(ptr_q) + k) % CHANNEL_NUM);
            if (!found && req_i[idx]) begin
               found       = 1'b1;
               winner      = idx;
               gnt_o[idx]  = 1'b1;
            end
         end
      end
   end

   assign valid_o = |gnt_o;
   assign hs      = valid_o && ready_i;

   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      lock_d  = lock_q;
      if (hs) begin
         if (tail_i[winner]) begin
            lock_d = 1'b0;
            ptr_d  = rr_next(winner);
         end else begin
            lock_d  = 1'b1;
            owner_d = winner;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         ptr_q   <= '0;
         owner_q <= '0;
         lock_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         lock_q  <= lock_d;
      end
   end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with registered full flag; ready_o never depends on the read side.
// Used once per router ingress channel (see ROUTER_XY_XBAR_WORMHOLE_EN in the top for packet mode).
module stream_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  push, pop;

   assign ready_o = (count_q != FULL_CNT);
   assign valid_o = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/router_xy_xbar.sv
// 5-port XY mesh router: per-input FIFOs, per-output round-robin arbiters, full crossbar.
// Define ROUTER_XY_XBAR_WORMHOLE_EN for multi-flit packets (data MSB = tail); otherwise every flit is a packet.
module router_xy_xbar
   import router_xy_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned X_WIDTH    = 2,
   parameter int unsigned Y_WIDTH    = 2,
   parameter int unsigned SOURCE_X   = 1,
   parameter int unsigned SOURCE_Y   = 1
) (
   input  logic                   clk_i,
   input  logic                   arstn_i,
   input  logic [DATA_WIDTH-1:0]  data_i [CHANNEL_NUM],
   input  logic [CHANNEL_NUM-1:0] valid_i,
   output logic [CHANNEL_NUM-1:0] ready_o,
   output logic [DATA_WIDTH-1:0]  data_o [CHANNEL_NUM],
   output logic [CHANNEL_NUM-1:0] valid_o,
   input  logic [CHANNEL_NUM-1:0] ready_i
);

   logic [DATA_WIDTH-1:0]  head     [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0] head_vld;
   logic [CHANNEL_NUM-1:0] pop;
   logic [CHANNEL_NUM-1:0] tail;
   port_e                  hdr_route [CHANNEL_NUM];
   port_e                  route     [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0] req       [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0] gnt       [CHANNEL_NUM];

   for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_in
      stream_fifo #(
         .DATA_WIDTH(DATA_WIDTH),
         .DEPTH     (FIFO_DEPTH)
      ) u_fifo (
         .clk_i  (clk_i),
         .arstn_i(arstn_i),
         .data_i (data_i[i]),
         .valid_i(valid_i[i]),
         .ready_o(ready_o[i]),
         .data_o (head[i]),
         .valid_o(head_vld[i]),
         .ready_i(pop[i])
      );
   end

   always_comb begin
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
         hdr_route[i] = xy_route(32'(head[i][X_WIDTH-1:0]),
                                 32'(head[i][X_WIDTH+Y_WIDTH-1:X_WIDTH]),
                                 SOURCE_X, SOURCE_Y);
      end
   end

`ifdef ROUTER_XY_XBAR_WORMHOLE_EN
   // Body/tail flits reuse the route captured when their head left the FIFO.
   logic [CHANNEL_NUM-1:0] busy_q, busy_d;
   port_e                  lroute_q [CHANNEL_NUM];
   port_e                  lroute_d [CHANNEL_NUM];

   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
         tail[i]     = head[i][DATA_WIDTH-1];
         route[i]    = busy_q[i] ? lroute_q[i] : hdr_route[i];
         lroute_d[i] = lroute_q[i];
         if (pop[i]) begin
            busy_d[i] = !tail[i];
            if (!busy_q[i]) lroute_d[i] = hdr_route[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         busy_q <= '0;
         for (int unsigned i = 0; i < CHANNEL_NUM; i++) lroute_q[i] <= LOCAL;
      end else begin
         busy_q <= busy_d;
         for (int unsigned i = 0; i < CHANNEL_NUM; i++) lroute_q[i] <= lroute_d[i];
      end
   end
`else
   always_comb begin
      tail = '1;
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) route[i] = hdr_route[i];
   end
`endif

   always_comb begin
      for (int unsigned o = 0; o < CHANNEL_NUM; o++) begin
         for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            req[o][i] = head_vld[i] && (route[i] == 3'(o));
         end
      end
   end

   for (genvar o = 0; o < CHANNEL_NUM; o++) begin : g_out
      router_xy_out_arb u_arb (
         .clk_i  (clk_i),
         .arstn_i(arstn_i),
         .req_i  (req[o]),
         .tail_i (tail),
         .ready_i(ready_i[o]),
         .gnt_o  (gnt[o]),
         .valid_o(valid_o[o])
      );
   end

   always_comb begin
      pop = '0;
      for (int unsigned o = 0; o < CHANNEL_NUM; o++) begin
         data_o[o] = '0;
         for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            if (gnt[o][i]) begin
               data_o[o] = data_o[o] | head[i];
               if (ready_i[o]) pop[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_router_xy_xbar.sv
// Scoreboard bench for router_xy_xbar at SOURCE=(1,1), FIFO_DEPTH=4; wormhole case under ROUTER_XY_XBAR_WORMHOLE_EN.
module tb_router_xy_xbar;
   import router_xy_pkg::*;

   localparam int unsigned N = 5;

   logic        clk = 1'b0;
   logic        arstn;
   logic [31:0] data_i [N];
   logic [31:0] data_o [N];
   logic [4:0]  valid_i, ready_o, valid_o, ready_i;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] expq [N][$];

   always #5 clk = ~clk;

   router_xy_xbar #(
      .DATA_WIDTH(32),
      .FIFO_DEPTH(4),
      .X_WIDTH   (2),
      .Y_WIDTH   (2),
      .SOURCE_X  (1),
      .SOURCE_Y  (1)
   ) dut (
      .clk_i  (clk),
      .arstn_i(arstn),
      .data_i (data_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .data_o (data_o),
      .valid_o(valid_o),
      .ready_i(ready_i)
   );

   function automatic logic [31:0] mk(input int unsigned x, input int unsigned y,
                                      input int unsigned tag, input logic tl = 1'b1);
      logic [31:0] f;
      f        = '0;
      f[31]    = tl;
      f[15:8]  = 8'(tag);
      f[3:2]   = 2'(y);
      f[1:0]   = 2'(x);
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds valid on the masked channels until each has been accepted.
   task automatic drive(input logic [4:0] mask);
      logic [4:0] pending, acc;
      int unsigned n;
      pending = mask;
      n = 0;
      valid_i = mask;
      while (pending != 0 && n < 20) begin
         @(negedge clk);
         acc = pending & ready_o;
         @(posedge clk);
         #1;
         pending = pending & ~acc;
         valid_i = pending;
         n++;
      end
      valid_i = '0;
      check("ingress accept", 32'(pending), 32'h0);
   endtask

   function automatic int unsigned outstanding();
      int unsigned s;
      s = 0;
      for (int o = 0; o < N; o++) s += expq[o].size();
      return s;
   endfunction

   task automatic wait_drain(input string name);
      int unsigned n;
      n = 0;
      while (outstanding() != 0 && n < 50) begin
         step();
         n++;
      end
      check(name, outstanding(), 32'h0);
   endtask

   always @(negedge clk) begin : monitor
      logic [31:0] e;
      if (arstn) begin
         for (int o = 0; o < N; o++) begin
            if (valid_o[o] && ready_i[o]) begin
               if (expq[o].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL out%0d unexpected: got %h expected nothing", o, data_o[o]);
               end else begin
                  e = expq[o].pop_front();
                  check($sformatf("out%0d data", o), data_o[o], e);
               end
            end else if (!valid_o[o]) begin
               check($sformatf("out%0d idle data", o), data_o[o], 32'h0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned xs [5] = '{2, 0, 1, 1, 1};
      int unsigned ys [5] = '{1, 1, 2, 0, 1};
      int unsigned ps [5] = '{2, 4, 1, 3, 0};

      arstn   = 1'b0;
      valid_i = '0;
      ready_i = '1;
      for (int i = 0; i < N; i++) data_i[i] = '0;

      @(negedge clk);
      check("reset valid_o", 32'(valid_o), 32'h0);
      check("reset ready_o", 32'(ready_o), 32'h1f);
      for (int o = 0; o < N; o++) check($sformatf("reset data_o%0d", o), data_o[o], 32'h0);
      step();
      arstn = 1'b1;
      repeat (2) step();

      // XY routing from the local port, one cycle after acceptance
      for (int k = 0; k < 5; k++) begin
         data_i[0] = mk(xs[k], ys[k], 32'h10 + k);
         expq[ps[k]].push_back(data_i[0]);
         drive(5'b00001);
         @(negedge clk);
         check($sformatf("route%0d valid_o", k), 32'(valid_o), 32'(1) << ps[k]);
         step();
      end
      wait_drain("route drain");

      // four inputs to four distinct outputs together
      data_i[1] = mk(1, 0, 32'h20); expq[3].push_back(data_i[1]);
      data_i[2] = mk(0, 1, 32'h21); expq[4].push_back(data_i[2]);
      data_i[3] = mk(1, 2, 32'h22); expq[1].push_back(data_i[3]);
      data_i[4] = mk(2, 1, 32'h23); expq[2].push_back(data_i[4]);
      drive(5'b11110);
      @(negedge clk);
      check("concurrent valid_o", 32'(valid_o), 32'h1e);
      step();
      wait_drain("concurrent drain");

      // east pointer is 0 here: inputs 0,1,3 win in that order twice
      ready_i[2] = 1'b0;
      for (int r = 0; r < 2; r++) begin
         data_i[0] = mk(2, 1, 32'h30 + r); expq[2].push_back(data_i[0]);
         data_i[1] = mk(2, 1, 32'h40 + r); expq[2].push_back(data_i[1]);
         data_i[3] = mk(2, 1, 32'h50 + r); expq[2].push_back(data_i[3]);
         drive(5'b01011);
      end
      ready_i[2] = 1'b1;
      step();
      ready_i[2] = 1'b0;
      repeat (3) step();
      ready_i[2] = 1'b1;
      wait_drain("rr drain");

      // full FIFO on input 0
      ready_i = '0;
      for (int k = 0; k < 4; k++) begin
         data_i[0] = mk(2, 1, 32'h60 + k);
         expq[2].push_back(data_i[0]);
         drive(5'b00001);
      end
      @(negedge clk);
      check("full ready_o0", 32'(ready_o[0]), 32'h0);
      step();
      data_i[0] = mk(2, 1, 32'h64);
      valid_i   = 5'b00001;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("full hold%0d ready_o0", k), 32'(ready_o[0]), 32'h0);
         step();
      end
      valid_i = '0;
      ready_i = '1;
      wait_drain("full drain");
      repeat (4) step();

      // reset with flits buffered
      ready_i = '0;
      data_i[0] = mk(2, 1, 32'h70); expq[2].push_back(data_i[0]);
      data_i[3] = mk(1, 2, 32'h71); expq[1].push_back(data_i[3]);
      drive(5'b01001);
      data_i[0] = mk(2, 1, 32'h72); expq[2].push_back(data_i[0]);
      drive(5'b00001);
      arstn = 1'b0;
      for (int o = 0; o < N; o++) expq[o].delete();
      ready_i = '1;
      @(negedge clk);
      check("midreset valid_o", 32'(valid_o), 32'h0);
      check("midreset ready_o", 32'(ready_o), 32'h1f);
      for (int o = 0; o < N; o++) check($sformatf("midreset data_o%0d", o), data_o[o], 32'h0);
      step();
      arstn = 1'b1;
      repeat (4) step();
      data_i[0] = mk(0, 1, 32'h73);
      expq[4].push_back(data_i[0]);
      drive(5'b00001);
      @(negedge clk);
      check("post-reset valid_o", 32'(valid_o), 32'h10);
      step();
      wait_drain("post-reset drain");

`ifdef ROUTER_XY_XBAR_WORMHOLE_EN
      // input 1 holds east across a gap; input 4's head must wait for the tail
      data_i[1] = mk(2, 1, 32'h80, 1'b0);
      expq[2].push_back(data_i[1]);
      expq[2].push_back(mk(0, 0, 32'h81, 1'b0));
      expq[2].push_back(mk(0, 1, 32'h82, 1'b1));
      expq[2].push_back(mk(2, 1, 32'h90, 1'b1));
      drive(5'b00010);
      step();
      data_i[4] = mk(2, 1, 32'h90, 1'b1);
      drive(5'b10000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("wh locked%0d valid_o2", k), 32'(valid_o[2]), 32'h0);
         step();
      end
      data_i[1] = mk(0, 0, 32'h81, 1'b0);
      drive(5'b00010);
      data_i[1] = mk(0, 1, 32'h82, 1'b1);
      drive(5'b00010);
      wait_drain("wormhole drain");
`endif

      repeat (4) step();
      for (int o = 0; o < N; o++) check($sformatf("final queue%0d", o), 32'(expq[o].size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
